// File: rtl/nn_layer_seq.sv
// Sequential fully-connected FP neuron layer sharing one external multiply-add unit.
// Optional build macro NN_SKIP_ZERO_EN skips MACs whose input operand is +/-0.
module nn_layer_seq #(
    parameter int exp_width  = 8,
    parameter int mant_width = 24,
    parameter int N_IN       = 2,
    parameter int N_OUT      = 2,
    localparam int DW        = exp_width + mant_width,
    localparam int DEPTH     = N_OUT * (N_IN + 1),
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic [2:0]            round_mode,
    input  logic                  cfg_we,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [DW-1:0]         cfg_wdata,
    input  logic [1:0]            act_mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*DW-1:0]    in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_OUT*DW-1:0]   out_data,
    output logic [4:0]            exceptions,
    output logic                  fu_start,
    output logic [DW-1:0]         fu_a,
    output logic [DW-1:0]         fu_b,
    output logic [DW-1:0]         fu_c,
    output logic [2:0]            fu_round,
    input  logic                  fu_done,
    input  logic [DW-1:0]         fu_result,
    input  logic [4:0]            fu_exc
);
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [DW-1:0] FP_ONE = {2'b00, {(exp_width-1){1'b1}}, {(mant_width-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACT, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   i_q, i_d;
    logic [JW-1:0]   j_q, j_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [4:0]      exc_q, exc_d;
    logic [1:0]      mode_q, mode_d;
    logic [DW-1:0]   x_q [N_IN];
    logic [DW-1:0]   x_d [N_IN];
    logic [DW-1:0]   out_q [N_OUT];
    logic [DW-1:0]   out_d [N_OUT];
    logic [DW-1:0]   rf [DEPTH];

    logic [ADDR_W-1:0] w_idx, bias_next_idx;
    logic              last_i, last_j, x_zero;

    function automatic logic [DW-1:0] act_f(input logic [DW-1:0] v, input logic [1:0] m);
        logic is_nan;
        is_nan = (&v[DW-2 -: exp_width]) && (|v[mant_width-2:0]);
        act_f = v;
        if (!is_nan) begin
            case (m)
                2'd1: if (v[DW-1]) act_f = '0;
                2'd2: act_f = (!v[DW-1] && (|v[DW-2:0])) ? FP_ONE : '0;
                default: act_f = v;
            endcase
        end
    endfunction

    assign w_idx         = ADDR_W'(j_q) * ADDR_W'(N_IN + 1) + ADDR_W'(i_q);
    assign bias_next_idx = (ADDR_W'(j_q) + ADDR_W'(1)) * ADDR_W'(N_IN + 1) + ADDR_W'(N_IN);
    assign last_i        = (i_q == IW'(N_IN - 1));
    assign last_j        = (j_q == JW'(N_OUT - 1));
    assign x_zero        = (x_q[i_q][DW-2:0] == '0);

    // Register file holds no reset so weights survive a layer restart.
    always_ff @(posedge clk) begin
        if (cfg_we && state_q == IDLE && 32'(cfg_addr) < DEPTH)
            rf[cfg_addr] <= cfg_wdata;
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign exceptions = exc_q;
    assign fu_a       = x_q[i_q];
    assign fu_b       = rf[w_idx];
    assign fu_c       = acc_q;
    assign fu_round   = round_mode;

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_pack
            assign out_data[gi*DW +: DW] = out_q[gi];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        acc_d    = acc_q;
        exc_d    = exc_q;
        mode_d   = mode_q;
        x_d      = x_q;
        out_d    = out_q;
        fu_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int k = 0; k < N_IN; k++) x_d[k] = in_data[k*DW +: DW];
                    mode_d  = act_mode;
                    acc_d   = rf[N_IN];
                    i_d     = '0;
                    j_d     = '0;
                    exc_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
`ifdef NN_SKIP_ZERO_EN
                if (x_zero) begin
                    if (last_i) state_d = ACT;
                    else        i_d = i_q + 1'b1;
                end else begin
                    fu_start = 1'b1;
                    state_d  = WAIT;
                end
`else
                fu_start = 1'b1;
                state_d  = WAIT;
`endif
            end
            WAIT: begin
                if (fu_done) begin
                    acc_d = fu_result;
                    exc_d = exc_q | fu_exc;
                    if (last_i) begin
                        state_d = ACT;
                    end else begin
                        i_d     = i_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ACT: begin
                out_d[j_q] = act_f(acc_q, mode_q);
                if (last_j) begin
                    state_d = DONE;
                end else begin
                    j_d     = j_q + 1'b1;
                    i_d     = '0;
                    acc_d   = rf[bias_next_idx];
                    state_d = ISSUE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            exc_q   <= '0;
            mode_q  <= '0;
            for (int k = 0; k < N_IN; k++)  x_q[k]   <= '0;
            for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            exc_q   <= exc_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            out_q   <= out_d;
        end
    end

    // Silences unused-bit warnings for the skip path in the default build.
    logic unused_ok;
    assign unused_ok = x_zero;
endmodule

// File: tb/tb_nn_layer_seq.sv
// Directed bench for nn_layer_seq: XOR hidden-layer weights, all activations,
// backpressure, exception stickiness, mid-flight reset and the zero-skip option.
module tb_nn_layer_seq;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_l;
    logic [2:0]    round_mode;
    logic          cfg_we;
    logic [2:0]    cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic [1:0]    act_mode;
    logic          in_valid, in_ready;
    logic [63:0]   in_data;
    logic          out_valid, out_ready;
    logic [63:0]   out_data;
    logic [4:0]    exceptions;
    logic          fu_start, fu_done;
    logic [DW-1:0] fu_a, fu_b, fu_c, fu_result;
    logic [2:0]    fu_round;
    logic [4:0]    fu_exc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nn_layer_seq dut (
        .clk(clk), .rst_l(rst_l), .round_mode(round_mode),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .act_mode(act_mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .exceptions(exceptions), .fu_start(fu_start),
        .fu_a(fu_a), .fu_b(fu_b), .fu_c(fu_c), .fu_round(fu_round),
        .fu_done(fu_done), .fu_result(fu_result), .fu_exc(fu_exc)
    );

    // FP32 <-> real conversion, exact for the small values used here.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Multiply-add unit model with programmable latency and one-shot exception injection.
    int          lat = 1;
    int          cnt = 0;
    int          start_cnt = 0;
    int          inj_idx = -1;
    logic [31:0] res = '0;
    logic [4:0]  res_exc = '0;

    always @(posedge clk) begin
        if (fu_start) begin
            res       <= r2f(f2r(fu_a) * f2r(fu_b) + f2r(fu_c));
            res_exc   <= (start_cnt == inj_idx) ? 5'b00100 : 5'b00000;
            start_cnt <= start_cnt + 1;
            cnt       <= lat;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end
    end

    assign fu_done   = (cnt == 1);
    assign fu_result = res;
    assign fu_exc    = fu_done ? res_exc : 5'b00000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [31:0] x0, input logic [31:0] x1,
                           input logic [1:0] mode, input logic [31:0] e0, input logic [31:0] e1,
                           input int elat, input logic [4:0] eexc);
        int n;
        in_data  = {x1, x0};
        act_mode = mode;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_exc_clear"}, exceptions, 5'd0);
        chk({tag, "_busy"}, in_ready, 1'b0);
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, elat);
        chk({tag, "_out0"}, out_data[31:0], e0);
        chk({tag, "_out1"}, out_data[63:32], e1);
        chk({tag, "_exc"}, exceptions, eexc);
        $display("vec %s x=(%h,%h) mode=%0d -> out=(%h,%h) exc=%b lat=%0d",
                 tag, x0, x1, mode, out_data[31:0], out_data[63:32], exceptions, n);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle_ready"}, in_ready, 1'b1);
        chk({tag, "_idle_valid"}, out_valid, 1'b0);
    endtask

    initial begin
        int s0;
        rst_l = 1'b0; round_mode = 3'd5; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        act_mode = 2'd0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        rst_l = 1'b1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_exc", exceptions, 5'd0);
        chk("rst_fu_start", fu_start, 1'b0);
        chk("fu_round", fu_round, 3'd5);
        $display("reset released");

        cfg_write(3'd0, 32'h40800000);
        cfg_write(3'd1, 32'h40800000);
        cfg_write(3'd2, 32'hc0000000);
        cfg_write(3'd3, 32'hc0800000);
        cfg_write(3'd4, 32'hc0800000);
        cfg_write(3'd5, 32'h40c00000);
        cfg_write(3'd6, 32'h7fc00000);
        cfg_write(3'd7, 32'h7fc00000);
        $display("weights loaded");

        run_vec("step01", 32'h0, 32'h3f800000, 2'd2, 32'h3f800000, 32'h3f800000, 10, 5'd0);
        release_out("step01");
        run_vec("step11", 32'h3f800000, 32'h3f800000, 2'd2, 32'h3f800000, 32'h0, 10, 5'd0);
        release_out("step11");
        run_vec("step00", 32'h0, 32'h0, 2'd2, 32'h0, 32'h3f800000, 10, 5'd0);
        release_out("step00");
        run_vec("relu01", 32'h0, 32'h3f800000, 2'd1, 32'h40000000, 32'h40000000, 10, 5'd0);
        release_out("relu01");
        run_vec("relu11", 32'h3f800000, 32'h3f800000, 2'd1, 32'h40c00000, 32'h0, 10, 5'd0);
        release_out("relu11");
        run_vec("id3_01", 32'h0, 32'h3f800000, 2'd3, 32'h40000000, 32'h40000000, 10, 5'd0);
        release_out("id3_01");

        // Backpressure with an attempted weight write while the result waits.
        run_vec("id11", 32'h3f800000, 32'h3f800000, 2'd0, 32'h40c00000, 32'hc0000000, 10, 5'd0);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 32'h0;
        for (int k = 0; k < 5; k++) begin
            tick();
            cfg_we = 1'b0;
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_data", out_data, {32'hc0000000, 32'h40c00000});
            $display("backpressure cycle %0d out=%h", k, out_data);
        end
        release_out("bp");
        run_vec("id11_again", 32'h3f800000, 32'h3f800000, 2'd0, 32'h40c00000, 32'hc0000000, 10, 5'd0);
        release_out("id11_again");

        // Exception flag on the third MAC of the vector, then cleared on the next accept.
        inj_idx = start_cnt + 2;
        run_vec("exc", 32'h0, 32'h3f800000, 2'd2, 32'h3f800000, 32'h3f800000, 10, 5'b00100);
        release_out("exc");
        run_vec("exc_clr", 32'h0, 32'h3f800000, 2'd2, 32'h3f800000, 32'h3f800000, 10, 5'd0);
        release_out("exc_clr");

        // Reset while waiting on a slow FU; its late result must be ignored.
        lat = 3;
        in_data = {32'h3f800000, 32'h3f800000}; act_mode = 2'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        chk("rstw_valid", out_valid, 1'b0);
        chk("rstw_ready", in_ready, 1'b1);
        repeat (4) tick();
        chk("late_ready", in_ready, 1'b1);
        chk("late_valid", out_valid, 1'b0);
        chk("late_exc", exceptions, 5'd0);
        chk("late_data", out_data, 64'd0);
        $display("reset in WAIT handled, late fu_done passed");
        lat = 1;

        s0 = start_cnt;
`ifdef NN_SKIP_ZERO_EN
        run_vec("skip00", 32'h0, 32'h0, 2'd2, 32'h0, 32'h3f800000, 6, 5'd0);
        chk("skip_starts", start_cnt - s0, 0);
`else
        run_vec("noskip00", 32'h0, 32'h0, 2'd2, 32'h0, 32'h3f800000, 10, 5'd0);
        chk("noskip_starts", start_cnt - s0, 4);
`endif
        release_out("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
